// File: rtl/pong_sound.sv
// pong_sound: classifies pong game events and plays one prioritised square-wave
// tone per event on a 1-bit audio pin.
// Ports:
//   clk_0        pixel clock
//   rst          asynchronous active-low reset
//   enable       1 = sound on, 0 = mute (forces IDLE)
//   sq_xpos/ypos square position; sq_shown square visible/moving
//   score_p1/p2  player scores; game_over, game_startup game-state flags
//   audio        square-wave output; busy tone playing
//   tone_id      0 none, 1 wall, 2 paddle, 3 score, 4 game over
module pong_sound #(
  parameter int unsigned MS_CYCLES   = 25_175,
  parameter int unsigned PADDLE_HALF = 27_432,
  parameter int unsigned WALL_HALF   = 55_945,
  parameter int unsigned SCORE_HALF  = 51_377,
  parameter int unsigned OVER_HALF   = 100_700,
  parameter int unsigned PADDLE_MS   = 96,
  parameter int unsigned WALL_MS     = 16,
  parameter int unsigned SCORE_MS    = 257,
  parameter int unsigned OVER_MS     = 500
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] sq_xpos,
  input  logic [9:0] sq_ypos,
  input  logic       sq_shown,
  input  logic [3:0] score_p1,
  input  logic [3:0] score_p2,
  input  logic       game_over,
  input  logic       game_startup,
  output logic       audio,
  output logic       busy,
  output logic [2:0] tone_id
);

  localparam int unsigned PH_W  = 17;
  localparam int unsigned PRE_W = 15;
  localparam int unsigned DUR_W = 9;

  localparam logic [PRE_W-1:0] MS_LAST = PRE_W'(MS_CYCLES - 1);

  localparam logic [2:0] ID_NONE   = 3'd0;
  localparam logic [2:0] ID_WALL   = 3'd1;
  localparam logic [2:0] ID_PADDLE = 3'd2;
  localparam logic [2:0] ID_SCORE  = 3'd3;
  localparam logic [2:0] ID_OVER   = 3'd4;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_q, state_d;
  logic [9:0]        prev_x, prev_y;
  logic [3:0]        prev_s1, prev_s2;
  logic              prev_over;
  logic              xdir, xdir_valid, ydir, ydir_valid;
  logic              xdir_d, xdir_valid_d, ydir_d, ydir_valid_d;
  logic [PH_W-1:0]   phase, phase_d, half_m1, half_m1_d;
  logic [PRE_W-1:0]  pre, pre_d;
  logic [DUR_W-1:0]  dur, dur_d;
  logic              audio_d, busy_d;
  logic [2:0]        tone_id_d;

  // Per-axis single-step detection; anything else is a respawn jump
  logic [9:0] dx, dy;
  logic       x_inc, x_dec, y_inc, y_dec;
  assign dx    = sq_xpos - prev_x;
  assign dy    = sq_ypos - prev_y;
  assign x_inc = (dx == 10'd1);
  assign x_dec = (dx == 10'h3FF);
  assign y_inc = (dy == 10'd1);
  assign y_dec = (dy == 10'h3FF);

  // Event classification; a score change to 0 is a game reset, not a point
  logic mute, paddle_ev, wall_ev, score_ev, over_ev, accept;
  logic [2:0] ev_id;
  assign mute      = game_startup | ~enable;
  assign paddle_ev = xdir_valid & (x_inc | x_dec) & (x_inc != xdir);
  assign wall_ev   = ydir_valid & (y_inc | y_dec) & (y_inc != ydir);
  assign score_ev  = ((score_p1 != prev_s1) && (score_p1 != 4'd0)) ||
                     ((score_p2 != prev_s2) && (score_p2 != 4'd0));
  assign over_ev   = game_over & ~prev_over;

  always_comb begin
    ev_id = ID_NONE;
    if (over_ev)        ev_id = ID_OVER;
    else if (score_ev)  ev_id = ID_SCORE;
    else if (paddle_ev) ev_id = ID_PADDLE;
    else if (wall_ev)   ev_id = ID_WALL;
  end

  // Equal priority restarts the current tone
  assign accept = ~mute && (ev_id != ID_NONE) && (ev_id >= tone_id);

  // Direction tracking
  always_comb begin
    xdir_d       = xdir;
    xdir_valid_d = xdir_valid;
    ydir_d       = ydir;
    ydir_valid_d = ydir_valid;
    if (!sq_shown)          xdir_valid_d = 1'b0;
    else if (x_inc)         begin xdir_d = 1'b1; xdir_valid_d = 1'b1; end
    else if (x_dec)         begin xdir_d = 1'b0; xdir_valid_d = 1'b1; end
    else if (dx != 10'd0)   xdir_valid_d = 1'b0;
    if (!sq_shown)          ydir_valid_d = 1'b0;
    else if (y_inc)         begin ydir_d = 1'b1; ydir_valid_d = 1'b1; end
    else if (y_dec)         begin ydir_d = 1'b0; ydir_valid_d = 1'b1; end
    else if (dy != 10'd0)   ydir_valid_d = 1'b0;
  end

  // Tone FSM next-state and outputs
  always_comb begin
    state_d   = state_q;
    audio_d   = audio;
    busy_d    = busy;
    tone_id_d = tone_id;
    phase_d   = phase;
    pre_d     = pre;
    dur_d     = dur;
    half_m1_d = half_m1;
    if (mute) begin
      state_d   = IDLE;
      audio_d   = 1'b0;
      busy_d    = 1'b0;
      tone_id_d = ID_NONE;
      phase_d   = '0;
      pre_d     = '0;
      dur_d     = '0;
    end else if (accept) begin
      state_d   = PLAY;
      audio_d   = 1'b1;
      busy_d    = 1'b1;
      tone_id_d = ev_id;
      phase_d   = '0;
      pre_d     = '0;
      case (ev_id)
        ID_OVER:   begin half_m1_d = PH_W'(OVER_HALF - 1);   dur_d = DUR_W'(OVER_MS);   end
        ID_SCORE:  begin half_m1_d = PH_W'(SCORE_HALF - 1);  dur_d = DUR_W'(SCORE_MS);  end
        ID_PADDLE: begin half_m1_d = PH_W'(PADDLE_HALF - 1); dur_d = DUR_W'(PADDLE_MS); end
        default:   begin half_m1_d = PH_W'(WALL_HALF - 1);   dur_d = DUR_W'(WALL_MS);   end
      endcase
    end else if (state_q == PLAY) begin
      if (phase == half_m1) begin
        phase_d = '0;
        audio_d = ~audio;
      end else begin
        phase_d = phase + PH_W'(1);
      end
      if (pre == MS_LAST) begin
        pre_d = '0;
        dur_d = dur - DUR_W'(1);
        if (dur == DUR_W'(1)) begin
          state_d   = IDLE;
          audio_d   = 1'b0;
          busy_d    = 1'b0;
          tone_id_d = ID_NONE;
        end
      end else begin
        pre_d = pre + PRE_W'(1);
      end
    end
  end

  // State, history and output registers
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_s1    <= '0;
      prev_s2    <= '0;
      prev_over  <= 1'b0;
      xdir       <= 1'b0;
      xdir_valid <= 1'b0;
      ydir       <= 1'b0;
      ydir_valid <= 1'b0;
      phase      <= '0;
      pre        <= '0;
      dur        <= '0;
      half_m1    <= '0;
      audio      <= 1'b0;
      busy       <= 1'b0;
      tone_id    <= ID_NONE;
    end else begin
      state_q    <= state_d;
      prev_x     <= sq_xpos;
      prev_y     <= sq_ypos;
      prev_s1    <= score_p1;
      prev_s2    <= score_p2;
      prev_over  <= game_over;
      xdir       <= xdir_d;
      xdir_valid <= xdir_valid_d;
      ydir       <= ydir_d;
      ydir_valid <= ydir_valid_d;
      phase      <= phase_d;
      pre        <= pre_d;
      dur        <= dur_d;
      half_m1    <= half_m1_d;
      audio      <= audio_d;
      busy       <= busy_d;
      tone_id    <= tone_id_d;
    end
  end

endmodule

// File: tb/tb_pong_sound.sv
// tb_pong_sound: directed self-checking bench for pong_sound using small
// tone/duration overrides so whole tones fit in a few dozen cycles.
module tb_pong_sound;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic       enable;
  logic [9:0] sq_xpos, sq_ypos;
  logic       sq_shown;
  logic [3:0] score_p1, score_p2;
  logic       game_over, game_startup;
  logic       audio, busy;
  logic [2:0] tone_id;

  int n_assert = 0;
  int n_fail   = 0;

  pong_sound #(
    .MS_CYCLES(10), .PADDLE_HALF(3), .WALL_HALF(2), .SCORE_HALF(4), .OVER_HALF(5),
    .PADDLE_MS(2), .WALL_MS(2), .SCORE_MS(2), .OVER_MS(4)
  ) dut (
    .clk_0(clk_0), .rst(rst), .enable(enable), .sq_xpos(sq_xpos), .sq_ypos(sq_ypos),
    .sq_shown(sq_shown), .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .game_startup(game_startup),
    .audio(audio), .busy(busy), .tone_id(tone_id)
  );

  always #5 clk_0 = ~clk_0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_audio"}, 32'(audio), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tone"}, 32'(tone_id), 32'd0);
  endtask

  initial begin
    // 1. Reset with arbitrary inputs, then a static visible square
    rst = 1'b0; enable = 1'b1; sq_xpos = 10'd123; sq_ypos = 10'd456; sq_shown = 1'b1;
    score_p1 = 4'd0; score_p2 = 4'd0; game_over = 1'b0; game_startup = 1'b0;
    tick(3);
    chk_idle("rst");
    sq_xpos = 10'd300; sq_ypos = 10'd200;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk_idle("static");
    end

    // 2. Wall bounce 200->201->202->201
    sq_ypos = 10'd201; tick(1); chk("wall_pre1", 32'(tone_id), 32'd0);
    sq_ypos = 10'd202; tick(1); chk("wall_pre2", 32'(tone_id), 32'd0);
    sq_ypos = 10'd201; tick(1);
    chk("wall_tone", 32'(tone_id), 32'd1);
    chk("wall_audio0", 32'(audio), 32'd1);
    chk("wall_busy0", 32'(busy), 32'd1);
    for (int k = 1; k < 20; k++) begin
      tick(1);
      chk("wall_audio", 32'(audio), 32'(((k / 2) % 2) == 0));
      chk("wall_busy", 32'(busy), 32'd1);
    end
    tick(1);
    chk_idle("wall_end");

    // 3. Respawn jump clears x validity
    sq_xpos = 10'd301; tick(1); chk("jump_a", 32'(tone_id), 32'd0);
    sq_xpos = 10'd320; tick(1); chk("jump_b", 32'(tone_id), 32'd0);
    sq_xpos = 10'd319; tick(1); chk("jump_c", 32'(tone_id), 32'd0);
    sq_xpos = 10'd320; tick(1);
    chk("paddle_tone", 32'(tone_id), 32'd2);
    chk("paddle_audio", 32'(audio), 32'd1);
    tick(19);
    chk("paddle_busy19", 32'(busy), 32'd1);
    tick(1);
    chk_idle("paddle_end");

    // 4. Preemption: set score 3 silently, then paddle then score
    game_startup = 1'b1; score_p1 = 4'd3; tick(2);
    chk_idle("startup_score");
    game_startup = 1'b0; tick(1);
    chk("no_stale_score", 32'(busy), 32'd0);
    sq_xpos = 10'd319; tick(1);
    chk("pre_paddle", 32'(tone_id), 32'd2);
    tick(4);
    chk("pre_paddle_audio4", 32'(audio), 32'd0);
    score_p1 = 4'd4; tick(1);
    chk("preempt_tone", 32'(tone_id), 32'd3);
    chk("preempt_audio", 32'(audio), 32'd1);
    tick(3);
    sq_ypos = 10'd202; tick(1);
    chk("ignore_wall_tone", 32'(tone_id), 32'd3);
    chk("ignore_wall_audio", 32'(audio), 32'd0);
    tick(15);
    chk("score_busy19", 32'(busy), 32'd1);
    chk("score_tone19", 32'(tone_id), 32'd3);
    tick(1);
    chk_idle("score_end");

    // 5. Game over and score change together: game over wins
    game_over = 1'b1; score_p1 = 4'd5; tick(1);
    chk("over_tone", 32'(tone_id), 32'd4);
    chk("over_audio0", 32'(audio), 32'd1);
    for (int k = 1; k < 40; k++) begin
      tick(1);
      chk("over_audio", 32'(audio), 32'(((k / 5) % 2) == 0));
      chk("over_busy", 32'(busy), 32'd1);
    end
    tick(1);
    chk_idle("over_end");

    // 6. Suppression by game_startup and enable
    game_over = 1'b0; tick(1);
    chk("over_fall", 32'(busy), 32'd0);
    game_startup = 1'b1;
    sq_ypos = 10'd201; tick(1); chk_idle("sup_wall");
    score_p2 = 4'd1;   tick(1); chk_idle("sup_score");
    game_startup = 1'b0; enable = 1'b0;
    sq_ypos = 10'd202; tick(1); chk_idle("mute_wall");
    score_p2 = 4'd2;   tick(1); chk_idle("mute_score");
    enable = 1'b1; tick(2);
    chk_idle("unmute");
    score_p2 = 4'd3; tick(1);
    chk("mid_tone", 32'(tone_id), 32'd3);
    tick(2);
    game_startup = 1'b1; tick(1);
    chk_idle("startup_silence");
    game_startup = 1'b0; tick(1);
    score_p2 = 4'd0; tick(1); chk_idle("score_zero2");
    score_p1 = 4'd0; tick(1); chk_idle("score_zero1");

    // Reset mid-tone silences at once and nothing replays
    score_p1 = 4'd1; tick(1);
    chk("rst_tone", 32'(busy), 32'd1);
    rst = 1'b0; score_p1 = 4'd0; #2;
    chk_idle("rst_async");
    tick(1);
    rst = 1'b1;
    tick(3);
    chk_idle("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
